cva6v_rvfi_commit_sequencer: RTL and testbench

- Sits downstream of the CVA6V RVFI packer; takes up to NrCommitPorts retired-instruction records per cycle and serializes them, oldest first, onto one backpressured trace channel (tracer, DPI or ISS comparator).
- Tags every accepted record with a monotonic retire-order number.
- Drops whole commit groups atomically when buffer space is short, and counts the drops.

---
 rtl/cva6v_rvfi_commit_sequencer.sv | 126 ++++++++++++
 tb/tb_cva6v_rvfi_commit_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6v_rvfi_commit_sequencer.sv
// Serializes up to NrCommitPorts retired RVFI records per cycle onto one backpressured
// trace channel, tagging each with a retire-order number and dropping whole groups on overflow.
module cva6v_rvfi_commit_sequencer #(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned FifoDepth     = 8,
    parameter type         rvfi_instr_t  = logic,
    parameter int unsigned OrderWidth    = 64,
    parameter int unsigned DropCntWidth  = 16,
    localparam int unsigned PortW = (NrCommitPorts > 1) ? $clog2(NrCommitPorts) : 1,
    localparam int unsigned IdxW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1,
    localparam int unsigned PtrW  = IdxW + 1,
    localparam int unsigned LvlW  = $clog2(FifoDepth) + 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   enable_i,
    input  logic                                   clear_i,
    input  logic        [NrCommitPorts-1:0]        commit_valid_i,
    input  rvfi_instr_t [NrCommitPorts-1:0]        commit_instr_i,
    output logic                                   trace_valid_o,
    input  logic                                   trace_ready_i,
    output rvfi_instr_t                            trace_instr_o,
    output logic        [PortW-1:0]                trace_port_o,
    output logic        [OrderWidth-1:0]           trace_order_o,
    output logic        [LvlW-1:0]                 fifo_level_o,
    output logic                                   overflow_o,
    output logic        [DropCntWidth-1:0]         drop_count_o
);

    rvfi_instr_t             instr_mem_q [FifoDepth];
    logic [PortW-1:0]        port_mem_q  [FifoDepth];
    logic [OrderWidth-1:0]   order_mem_q [FifoDepth];

    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [OrderWidth-1:0]   order_cnt_q;
    logic                    overflow_q;
    logic [DropCntWidth-1:0] drop_cnt_q;

    logic [NrCommitPorts-1:0] valid_eff;
    logic [LvlW-1:0]          n_push, free_slots, level;
    logic [LvlW-1:0]          slot_off [NrCommitPorts];
    logic [IdxW-1:0]          wr_slot  [NrCommitPorts];
    logic [IdxW-1:0]          rd_idx;
    logic [DropCntWidth:0]    drop_sum;
    logic                     pop, push, drop, empty, full;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                    (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    assign rd_idx = rd_ptr_q[IdxW-1:0];

    // Each valid port lands at wr_ptr + (number of lower-indexed valid ports): holes compact away.
    always_comb begin
        valid_eff = commit_valid_i & {NrCommitPorts{enable_i}};
        n_push    = '0;
        for (int unsigned i = 0; i < NrCommitPorts; i++) begin
            slot_off[i] = n_push;
            wr_slot[i]  = IdxW'(wr_ptr_q + PtrW'(slot_off[i]));
            n_push      = n_push + LvlW'(valid_eff[i]);
        end
        pop        = !empty && trace_ready_i;
        free_slots = LvlW'(FifoDepth) - level + LvlW'(pop);
        push       = !clear_i && (n_push != '0) && (n_push <= free_slots);
        drop       = !clear_i && (n_push > free_slots);
        drop_sum   = {1'b0, drop_cnt_q} + (DropCntWidth + 1)'(n_push);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            order_cnt_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + PtrW'(n_push);
                order_cnt_q <= order_cnt_q + OrderWidth'(n_push);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int unsigned i = 0; i < NrCommitPorts; i++) begin
                if (valid_eff[i]) begin
                    instr_mem_q[wr_slot[i]] <= commit_instr_i[i];
                    port_mem_q[wr_slot[i]]  <= PortW'(i);
                    order_mem_q[wr_slot[i]] <= order_cnt_q + OrderWidth'(slot_off[i]);
                end
            end
        end
    end

    assign trace_valid_o = !empty;
    assign trace_instr_o = empty ? '0 : instr_mem_q[rd_idx];
    assign trace_port_o  = empty ? '0 : port_mem_q[rd_idx];
    assign trace_order_o = empty ? '0 : order_mem_q[rd_idx];
    assign fifo_level_o  = level;
    assign overflow_o    = overflow_q;
    assign drop_count_o  = drop_cnt_q;

    a_no_over_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> (n_push <= free_slots));
    a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (trace_valid_o && trace_ready_i) |-> !empty);
    a_stable_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (trace_valid_o && !trace_ready_i && !clear_i) |=>
        (trace_valid_o && $stable(trace_instr_o) && $stable(trace_port_o) && $stable(trace_order_o)));
    a_level_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fifo_level_o <= LvlW'(FifoDepth)) && (full == (level == LvlW'(FifoDepth))));

endmodule

// File: tb/tb_cva6v_rvfi_commit_sequencer.sv
// Directed bench for cva6v_rvfi_commit_sequencer: queue-based reference model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_cva6v_rvfi_commit_sequencer;

    localparam int DEPTH = 8;

    logic             clk, rst_n, en, clear, trace_ready;
    logic [1:0]       commit_valid;
    logic [1:0][63:0] commit_instr;
    logic             trace_valid;
    logic [63:0]      trace_instr;
    logic [0:0]       trace_port;
    logic [63:0]      trace_order;
    logic [3:0]       fifo_level;
    logic             overflow;
    logic [15:0]      drop_count;

    int checks   = 0;
    int failures = 0;

    cva6v_rvfi_commit_sequencer #(
        .NrCommitPorts(2),
        .FifoDepth    (DEPTH),
        .rvfi_instr_t (logic [63:0]),
        .OrderWidth   (64),
        .DropCntWidth (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (en),
        .clear_i       (clear),
        .commit_valid_i(commit_valid),
        .commit_instr_i(commit_instr),
        .trace_valid_o (trace_valid),
        .trace_ready_i (trace_ready),
        .trace_instr_o (trace_instr),
        .trace_port_o  (trace_port),
        .trace_order_o (trace_order),
        .fifo_level_o  (fifo_level),
        .overflow_o    (overflow),
        .drop_count_o  (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: an ordered list of records, an order counter and drop bookkeeping.
    typedef struct packed {
        logic [63:0] instr;
        logic [0:0]  port;
        logic [63:0] order;
    } rec_t;

    rec_t        mq[$];
    logic [63:0] m_order;
    int unsigned m_drop;
    bit          m_ovf;
    bit          pre_order_req = 1'b0;
    logic [63:0] pre_order_val = '0;
    bit          pre_drop_req  = 1'b0;
    int unsigned pre_drop_val  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_order = '0;
            m_drop  = 0;
            m_ovf   = 1'b0;
        end else begin
            int   n;
            int   free;
            int   k;
            bit   pop;
            rec_t r;
            if (pre_order_req) m_order = pre_order_val;
            if (pre_drop_req)  m_drop  = pre_drop_val;
            n = 0;
            for (int p = 0; p < 2; p++) if (commit_valid[p] && en) n++;
            pop = (mq.size() != 0) && trace_ready;
            if (clear) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_drop = 0;
            end else begin
                if (pop) void'(mq.pop_front());
                free = DEPTH - mq.size();
                if (n > 0 && n <= free) begin
                    k = 0;
                    for (int p = 0; p < 2; p++) begin
                        if (commit_valid[p] && en) begin
                            r.instr = commit_instr[p];
                            r.port  = 1'(p);
                            r.order = m_order + 64'(k);
                            mq.push_back(r);
                            k++;
                        end
                    end
                    m_order = m_order + 64'(n);
                end else if (n > free) begin
                    m_ovf  = 1'b1;
                    m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid", 64'(trace_valid), 64'(mq.size() != 0));
            check("m_level", 64'(fifo_level), 64'(mq.size()));
            check("m_ovf", 64'(overflow), 64'(m_ovf));
            check("m_drop", 64'(drop_count), 64'(m_drop));
            if (mq.size() != 0) begin
                check("m_instr", trace_instr, mq[0].instr);
                check("m_port", 64'(trace_port), 64'(mq[0].port));
                check("m_order", trace_order, mq[0].order);
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                        input logic rdy);
        commit_valid    = v;
        commit_instr[0] = a;
        commit_instr[1] = b;
        trace_ready     = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(2'b00, '0, '0, rdy);
    endtask

    task automatic do_reset();
        commit_valid = '0;
        trace_ready  = 1'b0;
        clear        = 1'b0;
        en           = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(trace_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_instr", trace_instr, 64'd0);
        check("rst_port", 64'(trace_port), 64'd0);
        check("rst_order", trace_order, 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b1;
        clear        = 1'b0;
        trace_ready  = 1'b0;
        commit_valid = '0;
        commit_instr = '0;
        do_reset();

        // Two-port group, consumer always ready
        step(2'b11, 64'h8000_0000, 64'h8000_0004, 1'b1);
        check("t1_port0", 64'(trace_port), 64'd0);
        check("t1_order0", trace_order, 64'd0);
        check("t1_instr0", trace_instr, 64'h8000_0000);
        idle(1'b1);
        check("t1_port1", 64'(trace_port), 64'd1);
        check("t1_order1", trace_order, 64'd1);
        check("t1_instr1", trace_instr, 64'h8000_0004);
        idle(1'b1);
        check("t1_empty", 64'(trace_valid), 64'd0);
        check("t1_level", 64'(fifo_level), 64'd0);

        // Only port 1 valid, three cycles
        do_reset();
        step(2'b10, 64'h0, 64'h100, 1'b1);
        check("t2_port", 64'(trace_port), 64'd1);
        check("t2_order0", trace_order, 64'd0);
        step(2'b10, 64'h0, 64'h104, 1'b1);
        check("t2_order1", trace_order, 64'd1);
        step(2'b10, 64'h0, 64'h108, 1'b1);
        check("t2_order2", trace_order, 64'd2);
        check("t2_instr2", trace_instr, 64'h108);
        idle(1'b1);
        check("t2_level", 64'(fifo_level), 64'd0);

        // Fill under backpressure, drop a group, ignore while disabled, then drain
        do_reset();
        for (int g = 0; g < 4; g++) step(2'b11, 64'h1000 + 64'(8 * g), 64'h1004 + 64'(8 * g), 1'b0);
        check("t3_full", 64'(fifo_level), 64'd8);
        step(2'b11, 64'h1100, 64'h1104, 1'b0);
        check("t3_drop", 64'(drop_count), 64'd2);
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_level", 64'(fifo_level), 64'd8);
        check("t3_ordcnt", dut.order_cnt_q, 64'd8);
        check("t3_head", trace_instr, 64'h1000);
        check("t3_headord", trace_order, 64'd0);
        en = 1'b0;
        step(2'b11, 64'h1200, 64'h1204, 1'b0);
        en = 1'b1;
        check("t3_dis_drop", 64'(drop_count), 64'd2);
        for (int i = 0; i < 9; i++) idle(1'b1);
        check("t3_drained", 64'(fifo_level), 64'd0);
        check("t3_ovf_sticky", 64'(overflow), 64'd1);

        // Same-cycle pop frees a slot for a full group at level 7
        do_reset();
        step(2'b11, 64'h10, 64'h14, 1'b0);
        step(2'b11, 64'h18, 64'h1c, 1'b0);
        step(2'b11, 64'h20, 64'h24, 1'b0);
        step(2'b01, 64'h28, 64'h0, 1'b0);
        check("t4_lvl7", 64'(fifo_level), 64'd7);
        step(2'b11, 64'h30, 64'h34, 1'b1);
        check("t4_lvl8", 64'(fifo_level), 64'd8);
        check("t4_nodrop", 64'(drop_count), 64'd0);
        check("t4_head", trace_order, 64'd1);
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("t4_drained", 64'(fifo_level), 64'd0);

        // Clear with a same-cycle group; order continues across the clear
        do_reset();
        for (int g = 0; g < 4; g++) step(2'b11, 64'h40 + 64'(8 * g), 64'h44 + 64'(8 * g), 1'b0);
        step(2'b11, 64'h90, 64'h94, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("t5_lvl3", 64'(fifo_level), 64'd3);
        clear = 1'b1;
        step(2'b11, 64'h50, 64'h54, 1'b1);
        clear = 1'b0;
        check("t5_clr_lvl", 64'(fifo_level), 64'd0);
        check("t5_clr_ovf", 64'(overflow), 64'd0);
        check("t5_clr_drop", 64'(drop_count), 64'd0);
        step(2'b11, 64'h60, 64'h64, 1'b0);
        check("t5_order8", trace_order, 64'd8);
        idle(1'b1);
        check("t5_order9", trace_order, 64'd9);
        check("t5_instr9", trace_instr, 64'h64);
        do_reset();

        // Order counter wrap
        #2 force dut.order_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        pre_order_req = 1'b1;
        pre_order_val = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.order_cnt_q;
        step(2'b11, 64'h3000, 64'h3004, 1'b0);
        pre_order_req = 1'b0;
        check("t6_ord_max", trace_order, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1'b1);
        check("t6_ord_wrap", trace_order, 64'd0);
        check("t6_wrap_instr", trace_instr, 64'h3004);
        idle(1'b1);

        // Drop counter saturation
        #2 force dut.drop_cnt_q = 16'hFFFF;
        pre_drop_req = 1'b1;
        pre_drop_val = 65535;
        #1 release dut.drop_cnt_q;
        for (int g = 0; g < 4; g++) begin
            step(2'b11, 64'h4000 + 64'(8 * g), 64'h4004 + 64'(8 * g), 1'b0);
            pre_drop_req = 1'b0;
        end
        step(2'b11, 64'h4100, 64'h4104, 1'b0);
        check("t6_drop_sat", 64'(drop_count), 64'hFFFF);
        check("t6_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 9; i++) idle(1'b1);
        check("t6_drained", 64'(fifo_level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
